// File: rtl/pcf8575_req_sched.sv
// PCF8575 request scheduler: coalesces host writes and INT/poll reads into engine transactions, retrying NACKs.
// Latency: wr_en/rd_en rise two cycles after a request is latched while idle and the engine is free.
// Backpressure: holds in the request state while busy; at most one outstanding transaction until done.
module pcf8575_req_sched #(
    parameter logic [23:0] POLL_CYCLES = 24'd1000000,
    parameter int unsigned RETRY_MAX   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_wr,
    input  logic [15:0] host_wdata,
    input  logic        int_n,
    output logic        wr_en,
    output logic        rd_en,
    output logic [15:0] wdata,
    input  logic        busy,
    input  logic        done,
    input  logic        ack_err,
    input  logic [15:0] rdata,
    output logic [15:0] port_in,
    output logic        in_valid,
    output logic        in_changed,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

    localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);
    localparam logic [23:0] POLL_LAST = POLL_CYCLES - 24'd1;

    state_t      state, state_nxt;
    logic        int_s1, int_s2;
    logic        int_req;
    logic        wr_pend, rd_pend, boot_wr;
    logic [15:0] pend_wdata;
    logic [7:0]  retry_cnt;
    logic [23:0] poll_cnt;
    logic        poll_hit;
    logic        can_retry;
    logic        issue_wr, issue_rd;
    logic        wr_ok, rd_ok, wr_retry, rd_retry, wr_drop, rd_drop;

    assign int_req   = ~int_s2;
    assign poll_hit  = (POLL_CYCLES != 24'd0) && (poll_cnt == POLL_LAST);
    assign can_retry = retry_cnt < RETRY_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        wr_ok     = 1'b0;
        rd_ok     = 1'b0;
        wr_retry  = 1'b0;
        rd_retry  = 1'b0;
        wr_drop   = 1'b0;
        rd_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend || boot_wr) begin
                    state_nxt = WR_REQ;
                end else if (rd_pend) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_REQ: begin
                if (!busy) begin
                    issue_wr  = 1'b1;
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (done) begin
                    if (!ack_err) begin
                        wr_ok     = 1'b1;
                        state_nxt = IDLE;
                    end else if (can_retry) begin
                        wr_retry  = 1'b1;
                        state_nxt = WR_REQ;
                    end else begin
                        wr_drop   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            RD_REQ: begin
                if (!busy) begin
                    issue_rd  = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (done) begin
                    if (!ack_err) begin
                        rd_ok     = 1'b1;
                        state_nxt = IDLE;
                    end else if (can_retry) begin
                        rd_retry  = 1'b1;
                        state_nxt = RD_REQ;
                    end else begin
                        rd_drop   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b1;
            int_s2 <= 1'b1;
        end else begin
            int_s1 <= int_n;
            int_s2 <= int_s1;
        end
    end

    // A host write always wins; a NACK retry restores the in-flight payload unless newer data is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend    <= 1'b0;
            pend_wdata <= 16'hFFFF;
        end else if (host_wr) begin
            wr_pend    <= 1'b1;
            pend_wdata <= host_wdata;
        end else if (wr_retry) begin
            wr_pend <= 1'b1;
            if (!wr_pend) begin
                pend_wdata <= wdata;
            end
        end else if (issue_wr && !boot_wr) begin
            wr_pend <= 1'b0;
        end
    end

    // The post-reset all-inputs write is tracked apart from wr_pend so host data cannot displace it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_wr <= 1'b1;
            wdata   <= 16'hFFFF;
        end else if (issue_wr) begin
            boot_wr <= 1'b0;
            wdata   <= boot_wr ? 16'hFFFF : pend_wdata;
        end
    end

    // Set beats clear so an INT still active at completion earns one more read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            poll_cnt <= 24'd0;
        end else begin
            if (int_req || poll_hit) begin
                rd_pend <= 1'b1;
            end else if (rd_ok || rd_drop) begin
                rd_pend <= 1'b0;
            end
            if (rd_ok || rd_drop) begin
                poll_cnt <= 24'd0;
            end else if ((POLL_CYCLES != 24'd0) && !poll_hit) begin
                poll_cnt <= poll_cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (wr_ok || rd_ok || wr_drop || rd_drop) begin
                retry_cnt <= 8'd0;
            end else if (wr_retry || rd_retry) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (wr_drop || rd_drop) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            port_in    <= 16'hFFFF;
            in_valid   <= 1'b0;
            in_changed <= 1'b0;
        end else begin
            wr_en      <= issue_wr;
            rd_en      <= issue_rd;
            in_valid   <= rd_ok;
            in_changed <= rd_ok && (rdata != port_in);
            if (rd_ok) begin
                port_in <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_pcf8575_req_sched.sv
// Bench for pcf8575_req_sched: behavioural I2C engine plus a transaction-level model of expected traffic.
module tb_pcf8575_req_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_wr = 1'b0;
    logic [15:0] host_wdata = 16'h0000;
    logic        int_n = 1'b1;
    logic        wr_en, rd_en;
    logic [15:0] wdata;
    logic        busy, done, ack_err;
    logic [15:0] rdata;
    logic [15:0] port_in;
    logic        in_valid, in_changed, err;

    always #5 clk = ~clk;

    pcf8575_req_sched #(.POLL_CYCLES(24'd0), .RETRY_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .host_wr(host_wr), .host_wdata(host_wdata), .int_n(int_n),
        .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .port_in(port_in), .in_valid(in_valid), .in_changed(in_changed), .err(err)
    );

    typedef struct { bit nack; bit is_rd; logic [15:0] dat; } txn_t;

    txn_t        log_q[$];
    logic [15:0] rd_vals[$];
    logic [15:0] model_port = 16'hFFFF;
    int          total = 0, bad = 0;
    int          lat_min = 2, lat_max = 6, nack_pct = 0, nack_run = 0;
    bit          nack_all = 1'b0;
    bit          eng_active = 1'b0, cur_rd = 1'b0;
    logic [15:0] cur_data = 16'h0000;
    int          eng_cnt = 0, iv_cnt = 0, ic_cnt = 0, proto_bad = 0;

    // Engine and monitor act on the falling edge, away from the DUT's sampling edge.
    initial begin
        txn_t t;
        busy = 1'b0; done = 1'b0; ack_err = 1'b0; rdata = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0; ack_err = 1'b0;
            if (!rst_n) begin
                eng_active = 1'b0; busy = 1'b0;
            end else begin
                if (in_valid) iv_cnt++;
                if (in_changed) ic_cnt++;
                if (in_changed && !in_valid) proto_bad++;
                if (wr_en && rd_en) proto_bad++;
                if (eng_active) begin
                    if (wr_en || rd_en) proto_bad++;
                    if (!cur_rd && wdata !== cur_data) proto_bad++;
                    eng_cnt--;
                    if (eng_cnt <= 0) begin
                        done = 1'b1; busy = 1'b0; eng_active = 1'b0;
                        t.is_rd = cur_rd;
                        t.nack = nack_all || (nack_pct > 0 && nack_run < 2 && int'($urandom_range(0, 99)) < nack_pct);
                        nack_run = t.nack ? nack_run + 1 : 0;
                        ack_err = t.nack;
                        if (cur_rd) begin
                            rdata = (rd_vals.size() > 0) ? rd_vals.pop_front() : 16'($urandom);
                            t.dat = rdata;
                        end else begin
                            t.dat = cur_data;
                        end
                        log_q.push_back(t);
                    end
                end else if (wr_en || rd_en) begin
                    eng_active = 1'b1; busy = 1'b1; cur_rd = rd_en; cur_data = wdata;
                    eng_cnt = int'($urandom_range(lat_min, lat_max));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic host_write(input logic [15:0] d);
        host_wdata = d; host_wr = 1'b1;
        @(negedge clk); #1;
        host_wr = 1'b0;
    endtask

    task automatic wait_quiet(output bit to);
        int idle = 0, n = 0;
        to = 1'b0;
        while (idle < 30) begin
            @(negedge clk); #1;
            n++;
            if (eng_active || wr_en || rd_en) idle = 0; else idle++;
            if (n > 3000) begin to = 1'b1; break; end
        end
    endtask

    task automatic wait_start(output bit to);
        int n = 0;
        to = 1'b0;
        while (!eng_active) begin
            @(negedge clk); #1;
            n++;
            if (n > 200) begin to = 1'b1; break; end
        end
    endtask

    task automatic wait_logs(input int cnt, output bit to);
        int n = 0;
        to = 1'b0;
        while (log_q.size() < cnt) begin
            @(negedge clk); #1;
            n++;
            if (n > 500) begin to = 1'b1; break; end
        end
    endtask

    task automatic clear_stats();
        log_q.delete(); iv_cnt = 0; ic_cnt = 0;
    endtask

    task automatic test_reset();
        bit to;
        rst_n = 1'b0;
        idle_cycles(3);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        total++; if (wdata !== 16'hFFFF) begin bad++; $display("FAIL reset_wdata: got %h want ffff", wdata); end
        total++; if (port_in !== 16'hFFFF) begin bad++; $display("FAIL reset_port_in: got %h want ffff", port_in); end
        total++; if (in_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid: got %b want 0", in_valid); end
        total++; if (in_changed !== 1'b0) begin bad++; $display("FAIL reset_in_changed: got %b want 0", in_changed); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        clear_stats();
        lat_min = 2; lat_max = 6;
        rst_n = 1'b1;
        wait_quiet(to);
        total++; if (to) begin bad++; $display("FAIL boot_quiet: timed out, want idle"); end
        total++; if (log_q.size() != 1) begin bad++; $display("FAIL boot_count: got %0d want 1", log_q.size()); end
        if (log_q.size() > 0) begin
            total++; if (log_q[0].is_rd !== 1'b0) begin bad++; $display("FAIL boot_kind: got read want write"); end
            total++; if (log_q[0].dat !== 16'hFFFF) begin bad++; $display("FAIL boot_wdata: got %h want ffff", log_q[0].dat); end
        end
    endtask

    task automatic test_coalesce();
        bit to1, to2;
        clear_stats();
        lat_min = 8; lat_max = 8;
        host_write(16'h00A5);
        wait_start(to1);
        host_write(16'h1234);
        wait_quiet(to2);
        total++; if (to1 || to2) begin bad++; $display("FAIL coalesce_wait: timed out, want completion"); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL coalesce_count: got %0d want 2", log_q.size()); end
        if (log_q.size() == 2) begin
            total++; if (log_q[0].is_rd || log_q[0].dat !== 16'h00A5) begin bad++; $display("FAIL coalesce_first: got rd=%b %h want write 00a5", log_q[0].is_rd, log_q[0].dat); end
            total++; if (log_q[1].is_rd || log_q[1].dat !== 16'h1234) begin bad++; $display("FAIL coalesce_second: got rd=%b %h want write 1234", log_q[1].is_rd, log_q[1].dat); end
        end
        total++; if (wdata !== 16'h1234) begin bad++; $display("FAIL coalesce_wdata: got %h want 1234", wdata); end
    endtask

    task automatic test_int_read(input logic [15:0] v);
        bit to;
        int exp_ic;
        clear_stats();
        lat_min = 8; lat_max = 8;
        rd_vals.push_back(v);
        exp_ic = (v !== model_port) ? 1 : 0;
        model_port = v;
        int_n = 1'b0;
        idle_cycles(5);
        int_n = 1'b1;
        wait_quiet(to);
        total++; if (to) begin bad++; $display("FAIL int_read_quiet: timed out, want idle"); end
        total++; if (log_q.size() != 1 || (log_q.size() == 1 && !log_q[0].is_rd)) begin bad++; $display("FAIL int_read_count: got %0d txns want 1 read", log_q.size()); end
        total++; if (port_in !== v) begin bad++; $display("FAIL int_read_port_in: got %h want %h", port_in, v); end
        total++; if (iv_cnt != 1) begin bad++; $display("FAIL int_read_in_valid: got %0d pulses want 1", iv_cnt); end
        total++; if (ic_cnt != exp_ic) begin bad++; $display("FAIL int_read_in_changed: got %0d pulses want %0d", ic_cnt, exp_ic); end
    endtask

    task automatic test_int_held();
        bit to1, to2;
        logic [15:0] a, b;
        clear_stats();
        lat_min = 4; lat_max = 4;
        a = 16'($urandom); b = ~a;
        rd_vals.push_back(a); rd_vals.push_back(b);
        int_n = 1'b0;
        wait_logs(1, to1);
        int_n = 1'b1;
        wait_quiet(to2);
        model_port = b;
        total++; if (to1 || to2) begin bad++; $display("FAIL int_held_wait: timed out, want completion"); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL int_held_reads: got %0d want 2", log_q.size()); end
        total++; if (port_in !== b) begin bad++; $display("FAIL int_held_port_in: got %h want %h", port_in, b); end
        total++; if (iv_cnt != 2) begin bad++; $display("FAIL int_held_in_valid: got %0d want 2", iv_cnt); end
    endtask

    task automatic test_priority();
        bit to;
        logic [15:0] d, v;
        clear_stats();
        lat_min = 2; lat_max = 5;
        d = 16'($urandom); v = 16'($urandom);
        rd_vals.push_back(v);
        int_n = 1'b0;
        idle_cycles(2);
        host_write(d);
        int_n = 1'b1;
        wait_quiet(to);
        model_port = v;
        total++; if (to) begin bad++; $display("FAIL prio_quiet: timed out, want idle"); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL prio_count: got %0d want 2", log_q.size()); end
        if (log_q.size() == 2) begin
            total++; if (log_q[0].is_rd || log_q[0].dat !== d) begin bad++; $display("FAIL prio_first: got rd=%b %h want write %h", log_q[0].is_rd, log_q[0].dat, d); end
            total++; if (!log_q[1].is_rd || log_q[1].dat !== v) begin bad++; $display("FAIL prio_second: got rd=%b %h want read %h", log_q[1].is_rd, log_q[1].dat, v); end
        end
    endtask

    task automatic test_retry();
        bit to;
        int n_bad;
        logic [15:0] d;
        clear_stats();
        lat_min = 2; lat_max = 4;
        nack_all = 1'b1;
        d = 16'($urandom);
        host_write(d);
        wait_quiet(to);
        nack_all = 1'b0; nack_run = 0;
        n_bad = 0;
        foreach (log_q[k]) if (log_q[k].is_rd || !log_q[k].nack || log_q[k].dat !== d) n_bad++;
        total++; if (to) begin bad++; $display("FAIL retry_quiet: timed out, want idle"); end
        total++; if (log_q.size() != 3) begin bad++; $display("FAIL retry_attempts: got %0d want 3", log_q.size()); end
        total++; if (n_bad != 0) begin bad++; $display("FAIL retry_payload: got %0d odd attempts want 0", n_bad); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL retry_err: got %b want 1", err); end
        host_write(~d);
        wait_quiet(to);
        total++; if (log_q.size() != 4) begin bad++; $display("FAIL retry_recover: got %0d txns want 4", log_q.size()); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_random();
        logic [15:0] hv[$];
        logic [15:0] d, prev, last_rd, last_wr;
        int wi, exp_iv, exp_ic;
        bit to, ok;
        clear_stats();
        lat_min = 1; lat_max = 6; nack_pct = 20; nack_run = 0;
        prev = 16'h5A5A;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) prev = 16'($urandom);
            rd_vals.push_back(prev);
        end
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin d = 16'($urandom); hv.push_back(d); host_write(d); end
                2: begin int_n = 1'b0; idle_cycles(int'($urandom_range(1, 4))); int_n = 1'b1; end
                default: idle_cycles(int'($urandom_range(0, 8)));
            endcase
        end
        d = 16'($urandom); hv.push_back(d); host_write(d);
        wait_quiet(to);
        nack_pct = 0; nack_run = 0; rd_vals.delete();
        wi = 0; ok = 1'b1; exp_iv = 0; exp_ic = 0; last_rd = model_port; last_wr = 16'hFFFF;
        foreach (log_q[k]) begin
            if (!log_q[k].nack) begin
                if (log_q[k].is_rd) begin
                    exp_iv++;
                    if (log_q[k].dat !== last_rd) exp_ic++;
                    last_rd = log_q[k].dat;
                end else begin
                    while (wi < hv.size() && hv[wi] !== log_q[k].dat) wi++;
                    if (wi >= hv.size()) ok = 1'b0; else wi++;
                    last_wr = log_q[k].dat;
                end
            end
        end
        model_port = last_rd;
        total++; if (to) begin bad++; $display("FAIL rand_quiet: timed out, want idle"); end
        total++; if (!ok || wi != hv.size()) begin bad++; $display("FAIL rand_write_order: matched %0d of %0d host writes", wi, hv.size()); end
        total++; if (last_wr !== d || wdata !== d) begin bad++; $display("FAIL rand_last_write: got %h/%h want %h", last_wr, wdata, d); end
        total++; if (iv_cnt != exp_iv) begin bad++; $display("FAIL rand_in_valid: got %0d want %0d", iv_cnt, exp_iv); end
        total++; if (ic_cnt != exp_ic) begin bad++; $display("FAIL rand_in_changed: got %0d want %0d", ic_cnt, exp_ic); end
        total++; if (port_in !== last_rd) begin bad++; $display("FAIL rand_port_in: got %h want %h", port_in, last_rd); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rand_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [15:0] v;
        clear_stats();
        lat_min = 12; lat_max = 12;
        int_n = 1'b0;
        wait_start(to);
        int_n = 1'b1;
        total++; if (to || !cur_rd) begin bad++; $display("FAIL midrst_setup: got active=%b rd=%b want read in flight", eng_active, cur_rd); end
        idle_cycles(2);
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL midrst_en: got %b%b want 00", wr_en, rd_en); end
        total++; if (wdata !== 16'hFFFF) begin bad++; $display("FAIL midrst_wdata: got %h want ffff", wdata); end
        total++; if (port_in !== 16'hFFFF) begin bad++; $display("FAIL midrst_port_in: got %h want ffff", port_in); end
        total++; if (in_valid !== 1'b0 || in_changed !== 1'b0) begin bad++; $display("FAIL midrst_in_flags: got %b%b want 00", in_valid, in_changed); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", err); end
        idle_cycles(3);
        clear_stats(); rd_vals.delete();
        lat_min = 3; lat_max = 3;
        v = 16'($urandom);
        rd_vals.push_back(v);
        int_n = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
        int_n = 1'b1;
        wait_quiet(to);
        model_port = v;
        total++; if (to) begin bad++; $display("FAIL midrst_quiet: timed out, want idle"); end
        total++; if (log_q.size() != 2) begin bad++; $display("FAIL midrst_count: got %0d want 2", log_q.size()); end
        if (log_q.size() == 2) begin
            total++; if (log_q[0].is_rd || log_q[0].dat !== 16'hFFFF) begin bad++; $display("FAIL midrst_boot: got rd=%b %h want write ffff", log_q[0].is_rd, log_q[0].dat); end
            total++; if (!log_q[1].is_rd) begin bad++; $display("FAIL midrst_read: got write want read after boot"); end
        end
        total++; if (port_in !== v) begin bad++; $display("FAIL midrst_port_in_after: got %h want %h", port_in, v); end
    endtask

    initial begin
        test_reset();
        test_coalesce();
        test_int_read(16'hBEEF);
        test_int_read(16'hBEEF);
        test_int_held();
        test_priority();
        test_retry();
        test_random();
        test_reset_mid();
        total++; if (proto_bad != 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", proto_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcf8575_req_sched.md
PCF8575_REQ_SCHED -- requirements
Module: pcf8575_req_sched

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 24'd1000000, poll-timer period in clk cycles; 0 disables polling.
REQ-002 SHALL have parameter RETRY_MAX, default 2, retries after a NACKed transaction before abandoning it.
REQ-003 SHALL have port clk  input  1  system clock; all flops rise-edge triggered.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port host_wr  input  1  one-cycle request to drive host_wdata onto the expander pins.
REQ-006 SHALL have port host_wdata  input  16  requested output pattern; bit i = P(i).
REQ-007 SHALL have port int_n  input  1  expander INT line, active-low, asynchronous to clk.
REQ-008 SHALL have ports wr_en, rd_en  output  1 each  one-cycle transaction start pulses to the I2C engine.
REQ-009 SHALL have port wdata  output  16  write payload to the engine; stable from wr_en until done.
REQ-010 SHALL have ports busy, done, ack_err  input  1 each  engine status; done is a one-cycle pulse, ack_err is valid with done.
REQ-011 SHALL have port rdata  input  16  engine read result, valid with done on a read.
REQ-012 SHALL have ports port_in  output  16, in_valid  output  1, in_changed  output  1, err  output  1.

Function
REQ-013 SHALL synchronise int_n through two flops; int_req = synchronised int_n low.
REQ-014 SHALL latch host_wdata into pend_wdata and set wr_pend on every host_wr, in any state; the last write wins (coalescing).
REQ-015 SHALL set rd_pend when int_req is high or the poll counter reaches POLL_CYCLES-1; the poll counter reloads to 0 on every completed read.
REQ-016 SHALL implement FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
REQ-017 IDLE: if wr_pend go WR_REQ; else if rd_pend go RD_REQ; write has priority when both are pending.
REQ-018 WR_REQ: when busy=0, pulse wr_en for 1 cycle, copy pend_wdata to wdata, clear wr_pend, and go to WR_WAIT; hold while busy=1.
REQ-019 WR_WAIT: on done with ack_err=0, go IDLE and clear the retry count.
REQ-020 RD_REQ/RD_WAIT SHALL mirror WR_REQ/WR_WAIT using rd_en.
REQ-021 On a good read, SHALL clear rd_pend, register rdata into port_in, pulse in_valid for 1 cycle, and pulse in_changed in the same cycle if rdata differs from the previous port_in.
REQ-022 On done with ack_err=1: if retry count < RETRY_MAX, SHALL increment it and return to the REQ state, re-setting wr_pend for a write.
REQ-023 Otherwise SHALL set err (sticky), clear the retry count, drop the transaction, and go IDLE.
REQ-024 A host_wr arriving during WR_WAIT SHALL leave wr_pend set, so a second write follows after the current one completes.
REQ-025 int_req held low throughout a read SHALL cause exactly one further read after completion, not a continuous stream unless int_req is still low.
REQ-026 SHALL never assert wr_en and rd_en in the same cycle, and SHALL never start a new transaction before done for the outstanding one.
REQ-027 err SHALL clear only on reset.

Reset
REQ-028 On rst_n low, SHALL immediately force state=IDLE, wr_en=rd_en=0, wdata=16'hFFFF, port_in=16'hFFFF, in_valid=in_changed=err=0, wr_pend=rd_pend=0, and counters=0.
REQ-029 After rst_n deasserts, SHALL issue one write of 16'hFFFF (all quasi-inputs) before any read.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no done pending.

Verification
REQ-031 SHALL cover: after reset, engine idle -> wr_en with wdata=16'hFFFF; on done the FSM returns to IDLE.
REQ-032 SHALL cover: host_wr 16'h00A5, then 16'h1234 during WR_WAIT -> exactly two writes, the second with wdata=16'h1234.
REQ-033 SHALL cover: int_n low 5 cycles, engine returns rdata=16'hBEEF -> rd_en once, port_in=16'hBEEF, in_valid and in_changed pulse.
REQ-034 SHALL cover: a second read returns 16'hBEEF -> in_valid pulses and in_changed stays 0.
REQ-035 SHALL cover: RETRY_MAX=2, every done with ack_err=1 -> 3 wr_en pulses total, then err=1 and the FSM in IDLE.
REQ-036 SHALL cover: host_wr and int_req in the same cycle -> the write is issued before the read; rst_n pulsed low in RD_WAIT -> all outputs return to reset values.
